// File: rtl/data_sram_responder_if.sv
// SRAM-like data port between the memory stage (master) and a responder (slave).
interface data_sram_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed local data RAM answering the SRAM-like port with a fixed
// response latency; one request in flight, accepted in IDLE or in the prior RESP.
module data_sram_responder #(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h0
) (
    input  logic                 Clk,
    input  logic                 resetn,
    input  logic                 hold,
    data_sram_responder_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [32:0] LIMIT    = {1'b0, BASE} + 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [31:0]   mem [DEPTH];
    logic          vld_p0, err_p0;
    logic [AW-1:0] idx_p0;
    logic [31:0]   rdata_p0;
    logic          err_p1;
    logic [31:0]   rdata_p1;
    logic          err_q;
    logic [31:0]   rdata_q;

    function automatic logic req_err(input logic [31:0] a, input logic [1:0] sz);
        logic oow;
        oow = ({1'b0, a} < {1'b0, BASE}) || ({1'b0, a} >= LIMIT);
        return oow | (sz == 2'd3) | ((sz == 2'd1) & a[0]) |
               ((sz == 2'd2) & (a[1:0] != 2'b00));
    endfunction

    assign bus.addr_ok = ~hold & ((state == IDLE) | (state == RESP));
    assign vld_p0      = bus.req & bus.addr_ok;
    assign idx_p0      = bus.addr[AW+1:2];
    assign err_p0      = req_err(bus.addr, bus.size);
    assign rdata_p0    = (bus.wr | err_p0) ? 32'h0 : mem[idx_p0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (vld_p0) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'd1;
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // p0 -> p1: the write commits at the accept edge, so a read accepted later sees it
    always_ff @(posedge Clk) begin
        if (vld_p0) begin
            err_p1   <= err_p0;
            rdata_p1 <= rdata_p0;
            if (bus.wr & ~err_p0) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.wstrb[i]) mem[idx_p0][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // p1 -> response: with LATENCY==1 RESP is entered straight from the accept
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (state_nxt == RESP) begin
            rdata_q <= (state == WAIT) ? rdata_p1 : rdata_p0;
            err_q   <= (state == WAIT) ? err_p1   : err_p0;
        end
    end

    assign bus.data_ok = (state == RESP);
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (LATENCY 1/3/4) checked against
// a transaction-level RAM model with directed and random traffic.
module tb_data_sram_responder;
    localparam int DEPTH = 64;

    logic        Clk = 1'b0;
    logic        resetn;
    logic        req, wr, hold;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int          sel;
    logic        hold0, hold1, hold2;
    logic        aok_m, dok_m, err_m;
    logic [31:0] rdata_m;
    int          n_asrt = 0;
    int          n_fail = 0;
    logic [31:0] mdl [3][DEPTH];

    always #5 Clk = ~Clk;

    data_sram_responder_if bus0 ();
    data_sram_responder_if bus1 ();
    data_sram_responder_if bus2 ();

`define TB_DRIVE(b, k) \
    assign b.req = req & (sel == k); \
    assign b.wr = wr; \
    assign b.size = size; \
    assign b.addr = addr; \
    assign b.wstrb = wstrb; \
    assign b.wdata = wdata;

    `TB_DRIVE(bus0, 0)
    `TB_DRIVE(bus1, 1)
    `TB_DRIVE(bus2, 2)
    assign hold0 = hold & (sel == 0);
    assign hold1 = hold & (sel == 1);
    assign hold2 = hold & (sel == 2);

    data_sram_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE(32'h0))
        u0 (.Clk(Clk), .resetn(resetn), .hold(hold0), .bus(bus0));
    data_sram_responder #(.DEPTH(DEPTH), .LATENCY(3), .BASE(32'h0))
        u1 (.Clk(Clk), .resetn(resetn), .hold(hold1), .bus(bus1));
    data_sram_responder #(.DEPTH(DEPTH), .LATENCY(4), .BASE(32'h400))
        u2 (.Clk(Clk), .resetn(resetn), .hold(hold2), .bus(bus2));

    always_comb begin
        case (sel)
            0:       begin aok_m = bus0.addr_ok; dok_m = bus0.data_ok; rdata_m = bus0.rdata; err_m = bus0.err; end
            1:       begin aok_m = bus1.addr_ok; dok_m = bus1.data_ok; rdata_m = bus1.rdata; err_m = bus1.err; end
            default: begin aok_m = bus2.addr_ok; dok_m = bus2.data_ok; rdata_m = bus2.rdata; err_m = bus2.err; end
        endcase
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h400 : 32'h0;
    endfunction

    function automatic logic exp_err(input int k, input logic [31:0] a, input logic [1:0] sz);
        longint lo, hi;
        lo = longint'(base_of(k));
        hi = lo + 4 * DEPTH;
        return (longint'(a) < lo) || (longint'(a) >= hi) || (sz == 2'd3) ||
               (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated request: wait for accept, then for data_ok, compare with the model.
    task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] st, input logic [31:0] d, input string tag);
        int n;
        int i;
        logic e;
        logic [31:0] er;
        @(negedge Clk);
        req = 1'b1; wr = w; size = sz; addr = a; wstrb = st; wdata = d;
        #1;
        n = 0;
        while (!aok_m && n < 50) begin
            @(negedge Clk); #1; n++;
        end
        chk({tag, " accept"}, aok_m, 1'b1);
        e  = exp_err(sel, a, sz);
        i  = int'((a >> 2) % DEPTH);
        er = (w || e) ? 32'h0 : mdl[sel][i];
        if (w && !e) begin
            for (int b = 0; b < 4; b++) if (st[b]) mdl[sel][i][8*b +: 8] = d[8*b +: 8];
        end
        @(negedge Clk);
        req = 1'b0; wr = 1'b0;
        #1;
        n = 1;
        while (!dok_m && n < 20) begin
            @(negedge Clk); #1; n++;
        end
        chk({tag, " latency"}, n, lat_of(sel));
        chk({tag, " rdata"}, rdata_m, er);
        chk({tag, " err"}, err_m, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0, r1, a, d;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; hold = 1'b0; size = 2'd0;
        addr = 32'h0; wstrb = 4'h0; wdata = 32'h0; sel = 0;
        repeat (3) @(negedge Clk);
        #1;
        chk("reset data_ok", dok_m, 1'b0);
        chk("reset rdata", rdata_m, 32'h0);
        chk("reset err", err_m, 1'b0);
        chk("reset addr_ok", aok_m, 1'b1);
        hold = 1'b1; #1;
        chk("reset hold addr_ok", aok_m, 1'b0);
        hold = 1'b0;
        @(negedge Clk);
        resetn = 1'b1;

        for (int k = 0; k < 3; k++) begin
            sel = k;
            for (int w = 0; w < DEPTH; w++)
                txn(1'b1, 2'd2, base_of(k) + 32'(4 * w), 4'hF, $urandom, "fill");
        end

        sel = 0;
        txn(1'b1, 2'd2, 32'h10, 4'hF, 32'h12345678, "t1 write");
        txn(1'b0, 2'd2, 32'h10, 4'h0, 32'h0, "t1 read");
        chk("t1 const", rdata_m, 32'h12345678);
        txn(1'b1, 2'd0, 32'h11, 4'b0010, 32'h0000AB00, "t2 bwrite");
        txn(1'b0, 2'd2, 32'h10, 4'h0, 32'h0, "t2 read");
        chk("t2 const", rdata_m, 32'h1234AB78);

        txn(1'b0, 2'd1, 32'h13, 4'h0, 32'h0, "t4 half");
        chk("t4 half err", err_m, 1'b1);
        txn(1'b1, 2'd2, 32'(4 * DEPTH), 4'hF, 32'hDEADBEEF, "t4 oow");
        chk("t4 oow err", err_m, 1'b1);
        txn(1'b0, 2'd2, 32'h0, 4'h0, 32'h0, "t4 rb0");
        txn(1'b0, 2'd2, 32'h10, 4'h0, 32'h0, "t4 rb10");
        chk("t4 rb const", rdata_m, 32'h1234AB78);

        // write then read of the same word accepted in the write's RESP cycle
        d = 32'hA5C3_0F1E;
        @(negedge Clk);
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h30; wstrb = 4'hF; wdata = d;
        @(negedge Clk);
        wr = 1'b0; #1;
        chk("ord wr dok", dok_m, 1'b1);
        chk("ord wr aok", aok_m, 1'b1);
        chk("ord wr rdata", rdata_m, 32'h0);
        mdl[0][12] = d;
        @(negedge Clk);
        req = 1'b0; #1;
        chk("ord rd dok", dok_m, 1'b1);
        chk("ord rd rdata", rdata_m, d);

        sel = 1;
        r0 = mdl[1][8];
        r1 = mdl[1][9];
        @(negedge Clk);
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h20;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge Clk);
            if (k == 1) addr = 32'h24;
            if (k == 4) req = 1'b0;
            #1;
            chk($sformatf("t3 aok c%0d", k), aok_m, (k == 0 || k == 3 || k == 6 || k == 7));
            chk($sformatf("t3 dok c%0d", k), dok_m, (k == 3 || k == 6));
            if (k == 3) chk("t3 rdata0", rdata_m, r0);
            if (k == 6) chk("t3 rdata1", rdata_m, r1);
        end

        sel = 2;
        r0 = mdl[2][0];
        r1 = mdl[2][1];
        @(negedge Clk);
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h400;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge Clk);
            if (k == 1) addr = 32'h404;
            if (k == 8) req = 1'b0;
            hold = (k >= 1 && k <= 6);
            #1;
            chk($sformatf("t5 aok c%0d", k), aok_m, (k == 0 || k == 7 || k == 11));
            chk($sformatf("t5 dok c%0d", k), dok_m, (k == 4 || k == 11));
            if (k == 4)  chk("t5 rdata0", rdata_m, r0);
            if (k == 11) chk("t5 rdata1", rdata_m, r1);
        end
        hold = 1'b0;

        for (int k = 0; k < 3; k++) begin
            sel = k;
            for (int j = 0; j < 25; j++) begin
                a = base_of(k) + 32'($urandom_range(0, 271)) - ((k == 2) ? 32'd8 : 32'd0);
                if ($urandom % 2 == 0) a[1:0] = 2'b00;
                txn(1'($urandom % 2), 2'($urandom % 4), a, 4'($urandom), $urandom,
                    $sformatf("rnd%0d_%0d", k, j));
            end
        end

        sel = 1;
        txn(1'b0, 2'd2, 32'h2C, 4'h0, 32'h0, "t6 pre");
        @(negedge Clk);
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h28;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge Clk);
            if (k == 1) begin req = 1'b0; resetn = 1'b0; end
            if (k == 4) resetn = 1'b1;
            #1;
            chk($sformatf("t6 dok c%0d", k), dok_m, 1'b0);
            if (k >= 1) chk($sformatf("t6 aok c%0d", k), aok_m, 1'b1);
        end
        chk("t6 rdata", rdata_m, 32'h0);
        chk("t6 err", err_m, 1'b0);
        txn(1'b0, 2'd2, 32'h28, 4'h0, 32'h0, "t6 post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
